// File: rtl/rain_pkg.sv
// Shared types for the rain gauge control path: display sources, button FSM
// states and the 16-bit pulse-count type.
package rain_pkg;

   typedef logic [15:0] pulse_t;

   typedef enum logic [1:0] {
      MODE_TOTAL = 2'd0,
      MODE_RATE  = 2'd1,
      MODE_PEAK  = 2'd2
   } display_mode_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PRESS_DB = 3'd1,
      HELD     = 3'd2,
      LONG     = 3'd3,
      REL_DB   = 3'd4
   } btn_state_t;

   // Display source rotation on each short press; 3 is never produced.
   function automatic display_mode_t next_mode(input display_mode_t mode);
      case (mode)
         MODE_TOTAL: next_mode = MODE_RATE;
         MODE_RATE:  next_mode = MODE_PEAK;
         default:    next_mode = MODE_TOTAL;
      endcase
   endfunction

endpackage

// File: rtl/rain_button.sv
// Start/Adjust button: two-flop synchroniser plus debounce / hold FSM that
// produces one-cycle short_press and long_press strobes.
module rain_button
   import rain_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 16,
   parameter int LONG_PRESS_CYCLES = 1024
) (
   input  logic Clock,
   input  logic nReset,
   input  logic nButton,
   output logic short_press,
   output logic long_press
);

   localparam int CNT_MAX = (LONG_PRESS_CYCLES > DEBOUNCE_CYCLES) ? LONG_PRESS_CYCLES : DEBOUNCE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;
   localparam logic [CNT_W-1:0] DB_PRE  = CNT_W'(DEBOUNCE_CYCLES - 2);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

   logic             sync1;
   logic             btn_s;
   btn_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic             short_q;

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         sync1 <= 1'b1;
         btn_s <= 1'b1;
      end else begin
         sync1 <= nButton;
         btn_s <= sync1;
      end
   end

   // The sample that causes a transition counts toward the next window, so a
   // full press debounces in DEBOUNCE_CYCLES samples and holds for LONG_PRESS_CYCLES.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state   <= IDLE;
         cnt     <= '0;
         short_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!btn_s) begin
                  state <= PRESS_DB;
                  cnt   <= '0;
               end
            end
            PRESS_DB: begin
               if (btn_s) begin
                  state <= IDLE;
               end else if (cnt == DB_PRE) begin
                  state <= HELD;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HELD: begin
               if (btn_s) begin
                  state   <= REL_DB;
                  short_q <= 1'b1;
                  cnt     <= CNT_W'(1);
               end else if (cnt == LP_LAST) begin
                  state <= LONG;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            LONG: begin
               if (btn_s) begin
                  state   <= REL_DB;
                  short_q <= 1'b0;
                  cnt     <= CNT_W'(1);
               end
            end
            REL_DB: begin
               if (!btn_s) begin
                  cnt <= '0;
               end else if (cnt == DB_LAST) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Strobes mark the transition cycle so the consumer acts on the same edge.
   assign short_press = (state == REL_DB) && btn_s && (cnt == DB_LAST) && short_q;
   assign long_press  = (state == HELD) && !btn_s && (cnt == LP_LAST);

endmodule

// File: rtl/rain_controller.sv
// Rain gauge control: display-mode register, Tick-window rate/peak sampling,
// clear strobe generation and the registered display mux.
module rain_controller
   import rain_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 16,
   parameter int LONG_PRESS_CYCLES = 1024
) (
   input  logic        Clock,
   input  logic        nReset,
   input  logic        nButton,
   input  logic        Tick,
   input  logic [15:0] total_rain_pulses,
   output logic        nClear,
   output logic [1:0]  display_mode,
   output logic [15:0] rate_pulses,
   output logic [15:0] peak_pulses,
   output logic [15:0] display_pulses
);

   logic          short_press;
   logic          long_press;
   display_mode_t mode_q;
   pulse_t        snapshot;
   pulse_t        new_rate;

   rain_button #(
      .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
   ) u_button (
      .Clock       (Clock),
      .nReset      (nReset),
      .nButton     (nButton),
      .short_press (short_press),
      .long_press  (long_press)
   );

   // Modulo-2^16 subtraction handles wrap of the gauge total.
   assign new_rate     = total_rain_pulses - snapshot;
   assign display_mode = mode_q;

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         nClear         <= 1'b1;
         mode_q         <= MODE_TOTAL;
         snapshot       <= '0;
         rate_pulses    <= '0;
         peak_pulses    <= '0;
         display_pulses <= '0;
      end else begin
         nClear <= ~long_press;
         if (short_press)
            mode_q <= next_mode(mode_q);
         // A clear cycle takes priority and swallows a coincident Tick.
         if (!nClear) begin
            snapshot    <= '0;
            rate_pulses <= '0;
            peak_pulses <= '0;
         end else if (Tick) begin
            snapshot    <= total_rain_pulses;
            rate_pulses <= new_rate;
            if (new_rate > peak_pulses)
               peak_pulses <= new_rate;
         end
         case (mode_q)
            MODE_RATE: display_pulses <= rate_pulses;
            MODE_PEAK: display_pulses <= peak_pulses;
            default:   display_pulses <= total_rain_pulses;
         endcase
      end
   end

endmodule

// File: tb/tb_rain_controller.sv
// Directed bench for rain_controller with a scoreboard of expected values.
module tb_rain_controller;

   localparam int DB = 4;
   localparam int LP = 20;

   logic        Clock = 1'b0;
   logic        nReset;
   logic        nButton;
   logic        Tick;
   logic [15:0] total_rain_pulses;
   logic        nClear;
   logic [1:0]  display_mode;
   logic [15:0] rate_pulses;
   logic [15:0] peak_pulses;
   logic [15:0] display_pulses;

   rain_controller #(
      .DEBOUNCE_CYCLES   (DB),
      .LONG_PRESS_CYCLES (LP)
   ) dut (
      .Clock             (Clock),
      .nReset            (nReset),
      .nButton           (nButton),
      .Tick              (Tick),
      .total_rain_pulses (total_rain_pulses),
      .nClear            (nClear),
      .display_mode      (display_mode),
      .rate_pulses       (rate_pulses),
      .peak_pulses       (peak_pulses),
      .display_pulses    (display_pulses)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   clr_count = 0;
   int   m_clr = 0;

   logic [15:0] m_snap = 16'd0;
   logic [15:0] m_rate = 16'd0;
   logic [15:0] m_peak = 16'd0;
   int          m_mode = 0;

   always @(negedge Clock)
      if (nClear === 1'b0) clr_count++;

   task automatic cyc(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic expect_val(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty: observed %0d required an expectation", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic m_tick(input logic [15:0] t);
      logic [15:0] nr;
      nr = t - m_snap;
      m_rate = nr;
      m_snap = t;
      if (nr > m_peak) m_peak = nr;
   endtask

   task automatic m_clear();
      m_snap = 16'd0;
      m_rate = 16'd0;
      m_peak = 16'd0;
   endtask

   task automatic do_tick(input logic [15:0] t);
      total_rain_pulses = t;
      Tick = 1'b1;
      m_tick(t);
      expect_val("tick_rate", 32'(m_rate));
      expect_val("tick_peak", 32'(m_peak));
      cyc(1);
      Tick = 1'b0;
      check(32'(rate_pulses));
      check(32'(peak_pulses));
   endtask

   task automatic short_press();
      nButton = 1'b0;
      cyc(10);
      nButton = 1'b1;
      expect_val("mode_before_release_done", 32'(m_mode));
      cyc(5);
      check(32'(display_mode));
      m_mode = (m_mode + 1) % 3;
      expect_val("mode_after_release", 32'(m_mode));
      cyc(1);
      check(32'(display_mode));
   endtask

   task automatic long_press(input bit tick_on_clear, input logic [15:0] t);
      nButton = 1'b0;
      expect_val("nClear_before_edge26", 32'd1);
      cyc(25);
      check(32'(nClear));
      expect_val("nClear_at_edge26", 32'd0);
      cyc(1);
      check(32'(nClear));
      if (tick_on_clear) begin
         Tick = 1'b1;
         total_rain_pulses = t;
      end
      m_clear();
      m_clr++;
      cyc(1);
      Tick = 1'b0;
      expect_val("nClear_one_cycle", 32'd1);
      check(32'(nClear));
      expect_val("clear_rate", 32'(m_rate));
      check(32'(rate_pulses));
      expect_val("clear_peak", 32'(m_peak));
      check(32'(peak_pulses));
      cyc(14);
      nButton = 1'b1;
      expect_val("mode_after_long", 32'(m_mode));
      cyc(10);
      check(32'(display_mode));
      expect_val("clear_count_long", 32'(m_clr));
      check(32'(clr_count));
   endtask

   initial begin
      nReset = 1'b0;
      nButton = 1'b1;
      Tick = 1'b0;
      total_rain_pulses = 16'd0;
      cyc(2);
      expect_val("rst_nClear", 32'd1);
      check(32'(nClear));
      expect_val("rst_mode", 32'd0);
      check(32'(display_mode));
      expect_val("rst_rate", 32'd0);
      check(32'(rate_pulses));
      expect_val("rst_peak", 32'd0);
      check(32'(peak_pulses));
      expect_val("rst_display", 32'd0);
      check(32'(display_pulses));
      nReset = 1'b1;
      cyc(2);

      // Short presses cycle TOTAL -> RATE -> PEAK -> TOTAL.
      short_press();
      short_press();
      short_press();
      expect_val("no_clear_on_short", 32'(m_clr));
      check(32'(clr_count));

      // Display lags its source by one cycle.
      total_rain_pulses = 16'd1234;
      expect_val("display_lag", 32'd0);
      check(32'(display_pulses));
      cyc(1);
      expect_val("display_total", 32'd1234);
      check(32'(display_pulses));

      do_tick(16'd100);
      do_tick(16'd130);
      do_tick(16'd140);

      short_press();
      cyc(1);
      expect_val("display_rate", 32'(m_rate));
      check(32'(display_pulses));
      short_press();
      cyc(1);
      expect_val("display_peak", 32'(m_peak));
      check(32'(display_pulses));
      short_press();

      long_press(1'b0, 16'd0);

      do_tick(16'd20);
      do_tick(16'd50);
      do_tick(16'd60);

      do_tick(16'd65530);
      do_tick(16'd4);

      // Bounce shorter than the debounce window.
      nButton = 1'b0;
      cyc(3);
      nButton = 1'b1;
      expect_val("bounce_press_no_mode", 32'(m_mode));
      cyc(10);
      check(32'(display_mode));

      // Release with 1-cycle lows: exactly one advance.
      nButton = 1'b0;
      cyc(10);
      nButton = 1'b1;
      cyc(2);
      nButton = 1'b0;
      cyc(1);
      nButton = 1'b1;
      cyc(2);
      nButton = 1'b0;
      cyc(1);
      nButton = 1'b1;
      m_mode = (m_mode + 1) % 3;
      expect_val("bouncy_release_mode", 32'(m_mode));
      cyc(12);
      check(32'(display_mode));

      long_press(1'b1, 16'd999);
      do_tick(16'd77);

      // Asynchronous reset while HELD.
      nButton = 1'b0;
      cyc(10);
      nReset = 1'b0;
      #2;
      m_mode = 0;
      m_clear();
      expect_val("async_rst_mode", 32'd0);
      check(32'(display_mode));
      expect_val("async_rst_nClear", 32'd1);
      check(32'(nClear));
      expect_val("async_rst_rate", 32'd0);
      check(32'(rate_pulses));
      expect_val("async_rst_peak", 32'd0);
      check(32'(peak_pulses));
      nButton = 1'b1;
      cyc(2);
      nReset = 1'b1;
      cyc(40);
      expect_val("no_clear_after_reset", 32'(m_clr));
      check(32'(clr_count));
      expect_val("mode_after_reset", 32'd0);
      check(32'(display_mode));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
